load_store_unit: RTL and testbench

- Memory stage of the RV32I core. Takes one decoded load/store from execute over a valid/ready handshake.
- Issues one word-aligned request to data memory, waits for the memory response, then returns a writeback result to the register-file stage.
- Performs byte-lane masking, store-data lane placement, load sign/zero extension and misalignment detection.
- One transaction in flight at a time.

---
 rtl/rv32i_types.sv | 44 ++++
 rtl/lsu_lane_align.sv | 74 +++++++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rv32i_types
// Brief  : Shared RV32I encodings plus the load/store-unit state and request
//          types.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package rv32i_types;

  // Load funct3 encodings (011, 110 and 111 are not valid loads)
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_t;

  // Store funct3 encodings (anything from 011 upward is not a valid store)
  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_t;

  // Load/store unit control states
  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_t;

  // One latched load/store operation
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lsu_lane_align
// Brief  : Byte-lane mask generation, store data placement, load data
//          extraction/extension and legality check for one load/store.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module lsu_lane_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_placed,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic        legal_f3;

  assign shamt   = {offset, 3'b000};
  assign shifted = rdata >> shamt;

  // Lane selection and extension by access size (funct3[1:0]); funct3[2]
  // selects zero extension for loads
  always_comb begin
    mask         = 4'b0000;
    wdata_placed = 32'd0;
    rdata_ext    = 32'd0;
    bad          = 1'b0;
    legal_f3     = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        mask         = 4'b0001 << offset;
        wdata_placed = {24'd0, wdata[7:0]} << shamt;
        rdata_ext    = funct3[2] ? {24'd0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        bad          = offset[0];
        mask         = 4'b0011 << offset;
        wdata_placed = {16'd0, wdata[15:0]} << shamt;
        rdata_ext    = funct3[2] ? {16'd0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        bad          = (offset != 2'b00);
        mask         = 4'b1111;
        wdata_placed = wdata;
        rdata_ext    = rdata;
      end
      default: bad = 1'b1;
    endcase
    if (is_store) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: legal_f3 = 1'b1;
        default:             legal_f3 = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal_f3 = 1'b1;
        default:                             legal_f3 = 1'b0;
      endcase
    end
    if (!legal_f3) bad = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : load_store_unit
// Brief  : RV32I memory stage. Accepts one load/store, issues a single
//          word-aligned data-memory request, waits for the response and
//          returns a writeback result. Illegal/misaligned ops bypass memory.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module load_store_unit
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [4:0]        rsp_rd,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  // The datapath is RV32I-only; any other data width is a configuration error
  if (DATA_W != 32) begin : g_data_w_check
    $error("load_store_unit: DATA_W must be 32");
  end

  lsu_state_t  state, state_nx;
  lsu_req_t    req_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        is_idle;
  logic [2:0]  al_funct3;
  logic        al_is_store;
  logic [1:0]  al_offset;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_bad;

  assign is_idle = (state == LSU_IDLE);

  // In IDLE the aligner judges the incoming op; afterwards it works on the
  // latched op so a single instance serves both the check and the datapath.
  assign al_funct3   = is_idle ? req_funct3      : req_q.funct3;
  assign al_is_store = is_idle ? req_is_store    : req_q.is_store;
  assign al_offset   = is_idle ? req_addr[1:0]   : req_q.addr[1:0];

  lsu_lane_align u_align (
    .funct3       (al_funct3),
    .is_store     (al_is_store),
    .offset       (al_offset),
    .wdata        (req_q.wdata),
    .rdata        (rdata_q),
    .mask         (al_mask),
    .wdata_placed (al_wdata),
    .rdata_ext    (al_rdata),
    .bad          (al_bad)
  );

  // State register plus op/read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LSU_IDLE;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (is_idle && req_valid) begin
        req_q.is_store <= req_is_store;
        req_q.funct3   <= req_funct3;
        req_q.addr     <= 32'(req_addr);
        req_q.wdata    <= 32'(req_wdata);
        req_q.rd       <= req_rd;
        err_q          <= al_bad;
      end
      if (state == LSU_WAIT && dmem_resp) begin
        rdata_q <= dmem_rdata;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    dmem_addr  = '0;
    dmem_rmask = 4'b0000;
    dmem_wmask = 4'b0000;
    dmem_wdata = '0;
    rsp_valid  = 1'b0;
    rsp_we     = 1'b0;
    rsp_rd     = 5'd0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    case (state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = al_bad ? LSU_RESP : LSU_ISSUE;
      end
      LSU_ISSUE: begin
        dmem_addr = ADDR_W'({req_q.addr[31:2], 2'b00});
        if (req_q.is_store) begin
          dmem_wmask = al_mask;
          dmem_wdata = DATA_W'(al_wdata);
        end else begin
          dmem_rmask = al_mask;
        end
        state_nx = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (dmem_resp) state_nx = LSU_RESP;
      end
      LSU_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rd    = req_q.rd;
        rsp_we    = !err_q && !req_q.is_store && (req_q.rd != 5'd0);
        if (!err_q && !req_q.is_store) rsp_data = DATA_W'(al_rdata);
        if (rsp_ready) state_nx = LSU_IDLE;
      end
      default: state_nx = LSU_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_load_store_unit
// Brief  : Self-checking bench for load_store_unit with directed and random
//          load/store operations against a byte-level reference model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_resp = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .dmem_addr    (dmem_addr),
    .dmem_rmask   (dmem_rmask),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_we       (rsp_we),
    .rsp_rd       (rsp_rd),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, legality, byte-wise lane mapping
  task automatic ref_model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           output bit legal, output logic [3:0] mask,
                           output logic [31:0] wplaced, output logic [31:0] lval);
    int size;
    int off;
    bit sgn;
    off = int'(addr[1:0]);
    size = 0;
    sgn = 1'b0;
    if (st) begin
      case (f3)
        3'b000: size = 1;
        3'b001: size = 2;
        3'b010: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'b000: begin size = 1; sgn = 1'b1; end
        3'b001: begin size = 2; sgn = 1'b1; end
        3'b010: size = 4;
        3'b100: size = 1;
        3'b101: size = 2;
        default: size = 0;
      endcase
    end
    legal = (size != 0) && (off % size == 0);
    mask = 4'b0000;
    wplaced = 32'd0;
    lval = 32'd0;
    if (legal) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) begin
          mask[i] = 1'b1;
          wplaced[8*i +: 8] = wdata[8*(i-off) +: 8];
        end
      end
      for (int k = 0; k < size; k++) lval[8*k +: 8] = rdata[8*(off+k) +: 8];
      if (sgn && lval[8*size-1]) begin
        for (int b = 8*size; b < 32; b++) lval[b] = 1'b1;
      end
    end
  endtask

  // Full transaction: accept, request, memory reply after 'delay' WAIT cycles,
  // response held for 'bp' cycles of backpressure
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int delay, input int bp);
    bit          legal;
    logic [3:0]  emask;
    logic [31:0] ewd;
    logic [31:0] eld;
    logic [31:0] exp_data;
    ref_model(st, f3, addr, wdata, rdata, legal, emask, ewd, eld);
    exp_data = (legal && !st) ? eld : 32'd0;

    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    // scramble request inputs to prove the op was latched
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom); req_rd = 5'($urandom); req_is_store = 1'($urandom);
    if (!legal) begin
      check("err_rsp_valid_c1", 32'(rsp_valid), 32'd1);
      check("err_rsp_err", 32'(rsp_err), 32'd1);
      check("err_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
      check("err_rsp_we", 32'(rsp_we), 32'd0);
    end else begin
      check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
      check("issue_addr", dmem_addr, {addr[31:2], 2'b00});
      check("issue_rmask", 32'(dmem_rmask), st ? 32'd0 : 32'(emask));
      check("issue_wmask", 32'(dmem_wmask), st ? 32'(emask) : 32'd0);
      if (st) check("issue_wdata", dmem_wdata, ewd);
      for (int d = 0; d <= delay; d++) begin
        @(negedge clk);
        check("wait_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
        check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        if (d == delay) begin
          dmem_resp = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(negedge clk);
      dmem_resp = 1'b0;
      dmem_rdata = $urandom;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'd0);
      check("rsp_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    end
    check("rsp_req_ready", 32'(req_ready), 32'd0);
    check("rsp_we", 32'(rsp_we), 32'((!st) && legal && (rd != 5'd0)));
    check("rsp_rd", 32'(rsp_rd), 32'(rd));
    check("rsp_data", rsp_data, exp_data);
    for (int i = 0; i < bp; i++) begin
      dmem_resp = 1'b1;
      dmem_rdata = $urandom;
      @(negedge clk);
      dmem_resp = 1'b0;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", rsp_data, exp_data);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    check("reset_dmem_addr", dmem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // dmem_resp in IDLE must be ignored
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("idle_resp_ignored", 32'(rsp_valid), 32'd0);
    check("idle_resp_ready", 32'(req_ready), 32'd1);

    // Directed loads
    run_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd5, 32'h8012_3456, 0, 0);  // lb
    run_op(1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd6, 32'hBEEF_1234, 0, 0);  // lhu
    run_op(1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd7, 32'hBEEF_1234, 1, 0);  // lh
    run_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd0, 32'h8012_3456, 0, 0);  // lb rd=0
    // Directed stores
    run_op(1'b1, 3'b000, 32'h0000_0107, 32'hDEAD_BE5A, 5'd1, 32'd0, 0, 0);  // sb
    run_op(1'b1, 3'b001, 32'h0000_0104, 32'h0000_ABCD, 5'd2, 32'd0, 0, 0);  // sh
    run_op(1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 5'd3, 32'd0, 2, 0);  // sw
    // Error ops
    run_op(1'b0, 3'b010, 32'h0000_0102, 32'd0, 5'd4, 32'd0, 0, 0);  // misaligned lw
    run_op(1'b0, 3'b011, 32'h0000_0100, 32'd0, 5'd4, 32'd0, 0, 0);  // illegal load f3
    run_op(1'b1, 3'b011, 32'h0000_0100, 32'd0, 5'd4, 32'd0, 0, 2);  // illegal store f3
    // Backpressure on a completed lw
    run_op(1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd9, 32'hCAFE_F00D, 0, 4);

    // Reset while waiting for memory
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0300; req_rd = 5'd10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);  // now in WAIT
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("postrst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    run_op(1'b0, 3'b100, 32'h0000_0301, 32'd0, 5'd11, 32'h00C3_0000, 0, 0);  // lbu

    // Random operations
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom), $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
